// File: rtl/ex_mem_stage_pkg.sv
// Shared opcode encodings, flag-bit positions and datapath width defaults.
// Decode, the ALU and the EX/MEM boundary all import this package.
package ex_mem_stage_pkg;

   localparam int DW_DEF = 16;
   localparam int RW_DEF = 4;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LLB    = 4'b1010;
   localparam logic [3:0] OP_LHB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   // Per-bit {Z,V,N} write mask for an accepted instruction of the given opcode.
   function automatic logic [2:0] flag_write_mask(input logic [3:0] op);
      logic [2:0] m;
      m = 3'b000;
      case (op)
         OP_ADD, OP_SUB:                 m = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
         default:                        m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Three-bit {Z,V,N} flag register; each bit has its own write enable and data.
module flag_reg
   import ex_mem_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] we,
   input  logic [2:0] d,
   output logic [2:0] q
);

   logic [2:0] flags_d;
   logic [2:0] flags_q;

   always_comb begin
      flags_d = flags_q;
      for (int i = 0; i < 3; i++) begin
         if (we[i]) flags_d[i] = d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= 3'b000;
      else        flags_q <= flags_d;
   end

   assign q = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the ALU result and memory controls, updates
// the Z/V/N flags by opcode, and handles stall, flush and a sticky halt.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_valid,
   input  logic [3:0]    ex_opcode,
   input  logic [DW-1:0] ex_result,
   input  logic          ex_ovfl,
   input  logic [DW-1:0] ex_store_data,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_reg_wr,
   input  logic          stall,
   input  logic          flush,
   output logic          mem_valid,
   output logic [DW-1:0] mem_result,
   output logic [DW-1:0] mem_store_data,
   output logic [RW-1:0] mem_rd,
   output logic          mem_reg_wr,
   output logic          mem_rd_en,
   output logic          mem_wr_en,
   output logic [2:0]    flags,
   output logic          halt
);

   logic          advance;
   logic          accept;

   logic          valid_d,  valid_q;
   logic [DW-1:0] result_d, result_q;
   logic [DW-1:0] sdata_d,  sdata_q;
   logic [RW-1:0] rd_d,     rd_q;
   logic          reg_wr_d, reg_wr_q;
   logic          rd_en_d,  rd_en_q;
   logic          wr_en_d,  wr_en_q;
   logic          halt_d,   halt_q;

   logic [2:0]    flag_we;
   logic [2:0]    flag_val;

   assign advance = !stall;
   assign accept  = advance && ex_valid && !flush;

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      sdata_d  = sdata_q;
      rd_d     = rd_q;
      reg_wr_d = reg_wr_q;
      rd_en_d  = rd_en_q;
      wr_en_d  = wr_en_q;
      halt_d   = halt_q;
      if (advance) begin
         // Data fields load even for a bubble; only the controls are qualified.
         valid_d  = accept;
         result_d = ex_result;
         sdata_d  = ex_store_data;
         rd_d     = ex_rd;
         reg_wr_d = accept && ex_reg_wr;
         rd_en_d  = accept && (ex_opcode == OP_LW);
         wr_en_d  = accept && (ex_opcode == OP_SW);
      end
      if (accept && (ex_opcode == OP_HLT)) halt_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         sdata_q  <= '0;
         rd_q     <= '0;
         reg_wr_q <= 1'b0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         sdata_q  <= sdata_d;
         rd_q     <= rd_d;
         reg_wr_q <= reg_wr_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         halt_q   <= halt_d;
      end
   end

   always_comb begin
      flag_we          = accept ? flag_write_mask(ex_opcode) : 3'b000;
      flag_val         = 3'b000;
      flag_val[FLAG_Z] = (ex_result == '0);
      flag_val[FLAG_V] = ex_ovfl;
      flag_val[FLAG_N] = ex_result[DW-1];
   end

   flag_reg u_flag_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (flag_we),
      .d     (flag_val),
      .q     (flags)
   );

   assign mem_valid      = valid_q;
   assign mem_result     = result_q;
   assign mem_store_data = sdata_q;
   assign mem_rd         = rd_q;
   assign mem_reg_wr     = reg_wr_q;
   assign mem_rd_en      = rd_en_q;
   assign mem_wr_en      = wr_en_q;
   assign halt           = halt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table plus stall, halt and
// asynchronous-reset sequences.
module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_result;
   logic        ex_ovfl;
   logic [15:0] ex_store_data;
   logic [3:0]  ex_rd;
   logic        ex_reg_wr;
   logic        stall;
   logic        flush;
   logic        mem_valid;
   logic [15:0] mem_result;
   logic [15:0] mem_store_data;
   logic [3:0]  mem_rd;
   logic        mem_reg_wr;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [2:0]  flags;
   logic        halt;

   int n_cmp = 0;
   int n_err = 0;

   ex_mem_stage #(.DW(16), .RW(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_result      (ex_result),
      .ex_ovfl        (ex_ovfl),
      .ex_store_data  (ex_store_data),
      .ex_rd          (ex_rd),
      .ex_reg_wr      (ex_reg_wr),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_result     (mem_result),
      .mem_store_data (mem_store_data),
      .mem_rd         (mem_rd),
      .mem_reg_wr     (mem_reg_wr),
      .mem_rd_en      (mem_rd_en),
      .mem_wr_en      (mem_wr_en),
      .flags          (flags),
      .halt           (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [3:0]  op;
      logic [15:0] res;
      logic        ovf;
      logic [15:0] sd;
      logic [3:0]  rd;
      logic        rw;
      logic        stl;
      logic        fl;
      logic        e_vld;
      logic [15:0] e_res;
      logic [15:0] e_sd;
      logic [3:0]  e_rd;
      logic        e_rw;
      logic        e_rden;
      logic        e_wren;
      logic [2:0]  e_flags;
      logic        e_halt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                        input logic ovf, input logic [15:0] sd, input logic [3:0] rd,
                        input logic rw, input logic stl, input logic fl);
      ex_valid      = v;
      ex_opcode     = op;
      ex_result     = res;
      ex_ovfl       = ovf;
      ex_store_data = sd;
      ex_rd         = rd;
      ex_reg_wr     = rw;
      stall         = stl;
      flush         = fl;
   endtask

   task automatic check_all(input string tag, input logic e_vld, input logic [15:0] e_res,
                            input logic [15:0] e_sd, input logic [3:0] e_rd, input logic e_rw,
                            input logic e_rden, input logic e_wren, input logic [2:0] e_flags,
                            input logic e_halt);
      check({tag, ".mem_valid"},      {15'd0, mem_valid},  {15'd0, e_vld});
      check({tag, ".mem_result"},     mem_result,          e_res);
      check({tag, ".mem_store_data"}, mem_store_data,      e_sd);
      check({tag, ".mem_rd"},         {12'd0, mem_rd},     {12'd0, e_rd});
      check({tag, ".mem_reg_wr"},     {15'd0, mem_reg_wr}, {15'd0, e_rw});
      check({tag, ".mem_rd_en"},      {15'd0, mem_rd_en},  {15'd0, e_rden});
      check({tag, ".mem_wr_en"},      {15'd0, mem_wr_en},  {15'd0, e_wren});
      check({tag, ".flags"},          {13'd0, flags},      {13'd0, e_flags});
      check({tag, ".halt"},           {15'd0, halt},       {15'd0, e_halt});
   endtask

   task automatic row(input logic v, input logic [3:0] op, input logic [15:0] res, input logic ovf,
                      input logic [15:0] sd, input logic [3:0] rd, input logic rw,
                      input logic stl, input logic fl,
                      input logic e_vld, input logic [15:0] e_res, input logic [15:0] e_sd,
                      input logic [3:0] e_rd, input logic e_rw, input logic e_rden,
                      input logic e_wren, input logic [2:0] e_flags, input logic e_halt);
      vec_t t;
      t.vld = v;  t.op = op;  t.res = res;  t.ovf = ovf;  t.sd = sd;
      t.rd = rd;  t.rw = rw;  t.stl = stl;  t.fl = fl;
      t.e_vld = e_vld;  t.e_res = e_res;  t.e_sd = e_sd;  t.e_rd = e_rd;
      t.e_rw = e_rw;  t.e_rden = e_rden;  t.e_wren = e_wren;
      t.e_flags = e_flags;  t.e_halt = e_halt;
      vecs.push_back(t);
   endtask

   initial begin
      //  v  op         res       ovf sd        rd    rw   st fl | vld res       sd        rd    rw rden wren flags   halt
      row(1, OP_ADD,    16'h0000, 1, 16'h0000, 4'd3,  1,  0, 0,  1, 16'h0000, 16'h0000, 4'd3,  1, 0, 0, 3'b110, 0);
      row(1, OP_ADD,    16'h8001, 0, 16'h0000, 4'd4,  1,  0, 0,  1, 16'h8001, 16'h0000, 4'd4,  1, 0, 0, 3'b001, 0);
      row(1, OP_PADDSB, 16'h7F80, 1, 16'h0000, 4'd5,  1,  0, 0,  1, 16'h7F80, 16'h0000, 4'd5,  1, 0, 0, 3'b001, 0);
      row(1, OP_SUB,    16'h9000, 1, 16'h0000, 4'd6,  1,  0, 0,  1, 16'h9000, 16'h0000, 4'd6,  1, 0, 0, 3'b011, 0);
      row(1, OP_XOR,    16'h8000, 1, 16'h0000, 4'd7,  1,  0, 0,  1, 16'h8000, 16'h0000, 4'd7,  1, 0, 0, 3'b011, 0);
      row(1, OP_XOR,    16'h0000, 0, 16'h0000, 4'd8,  1,  0, 0,  1, 16'h0000, 16'h0000, 4'd8,  1, 0, 0, 3'b111, 0);
      row(1, OP_RED,    16'h0000, 0, 16'h0000, 4'd9,  1,  0, 0,  1, 16'h0000, 16'h0000, 4'd9,  1, 0, 0, 3'b111, 0);
      row(1, OP_LW,     16'h0040, 0, 16'h0000, 4'd10, 1,  0, 0,  1, 16'h0040, 16'h0000, 4'd10, 1, 1, 0, 3'b111, 0);
      row(1, OP_SW,     16'h0042, 0, 16'hBEEF, 4'd0,  0,  0, 0,  1, 16'h0042, 16'hBEEF, 4'd0,  0, 0, 1, 3'b111, 0);
      row(1, OP_SW,     16'h0044, 0, 16'hCAFE, 4'd1,  1,  0, 1,  0, 16'h0044, 16'hCAFE, 4'd1,  0, 0, 0, 3'b111, 0);
      row(0, OP_ADD,    16'h1234, 0, 16'h0000, 4'd2,  1,  0, 0,  0, 16'h1234, 16'h0000, 4'd2,  0, 0, 0, 3'b111, 0);
      row(0, OP_LW,     16'h0050, 0, 16'h0000, 4'd3,  1,  0, 0,  0, 16'h0050, 16'h0000, 4'd3,  0, 0, 0, 3'b111, 0);
      row(1, OP_SLL,    16'h0001, 0, 16'h0000, 4'd4,  1,  0, 0,  1, 16'h0001, 16'h0000, 4'd4,  1, 0, 0, 3'b011, 0);
      row(1, OP_SRA,    16'h0000, 0, 16'h0000, 4'd5,  1,  0, 0,  1, 16'h0000, 16'h0000, 4'd5,  1, 0, 0, 3'b111, 0);
      row(1, OP_ROR,    16'h0010, 0, 16'h0000, 4'd6,  1,  0, 0,  1, 16'h0010, 16'h0000, 4'd6,  1, 0, 0, 3'b011, 0);
      row(1, OP_ADD,    16'h0000, 0, 16'h0000, 4'd7,  1,  0, 0,  1, 16'h0000, 16'h0000, 4'd7,  1, 0, 0, 3'b100, 0);
      row(1, OP_SUB,    16'h0000, 1, 16'h1111, 4'd9,  1,  1, 1,  1, 16'h0000, 16'h0000, 4'd7,  1, 0, 0, 3'b100, 0);
      row(1, OP_LLB,    16'h00AB, 1, 16'h0000, 4'd8,  1,  0, 0,  1, 16'h00AB, 16'h0000, 4'd8,  1, 0, 0, 3'b100, 0);
      row(1, OP_B,      16'h0000, 1, 16'h0000, 4'd0,  0,  0, 0,  1, 16'h0000, 16'h0000, 4'd0,  0, 0, 0, 3'b100, 0);

      drive(0, OP_ADD, 16'h0, 0, 16'h0, 4'd0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 3'b000, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].vld, vecs[i].op, vecs[i].res, vecs[i].ovf, vecs[i].sd,
               vecs[i].rd, vecs[i].rw, vecs[i].stl, vecs[i].fl);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_res, vecs[i].e_sd,
                   vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_rden, vecs[i].e_wren,
                   vecs[i].e_flags, vecs[i].e_halt);
      end

      // SUB held three edges by stall, then released.
      drive(1, OP_SUB, 16'h8000, 1, 16'h0000, 4'd9, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_all($sformatf("stall%0d", k), 1, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 3'b100, 0);
      end
      stall = 1'b0;
      @(posedge clk);
      #1;
      check_all("stall_rel", 1, 16'h8000, 16'h0000, 4'd9, 1, 0, 0, 3'b011, 0);

      // Flushed HLT must not set halt; an accepted one must, and it sticks.
      drive(1, OP_HLT, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 1);
      @(posedge clk);
      #1;
      check("hlt_flushed.halt", {15'd0, halt}, 16'd0);
      drive(1, OP_HLT, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("hlt.halt", {15'd0, halt}, 16'd1);
      check("hlt.flags", {13'd0, flags}, {13'd0, 3'b011});
      for (int k = 0; k < 10; k++) begin
         drive(0, OP_ADD, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0);
         @(posedge clk);
         #1;
         check($sformatf("halt_sticky%0d", k), {15'd0, halt}, 16'd1);
      end

      // Asynchronous reset between edges while a valid ADD sits in MEM.
      drive(1, OP_ADD, 16'h5555, 0, 16'h7777, 4'd5, 1, 0, 0);
      @(posedge clk);
      #1;
      check("pre_rst.mem_result", mem_result, 16'h5555);
      #1;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 3'b000, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, OP_ADD, 16'h0000, 1, 16'h0000, 4'd2, 1, 0, 0);
      @(posedge clk);
      #1;
      check_all("post_rst", 1, 16'h0000, 16'h0000, 4'd2, 1, 0, 0, 3'b110, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
